vend_ctrl: RTL
==============

Name: vend_ctrl

Overview:
- Parametrised successor to the fixed-price newspaper vending FSM.
- Accepts nickel/dime/quarter pulses and accumulates credit toward a configurable PRICE.
- At or above PRICE: pulses release, then pays change serially, one coin per cycle, largest denomination first.
- Adds a cancel/refund path, rejection of illegal or mid-transaction coins, and a visible credit register.

Parameters:
- PRICE, 35: item price in cents. Must be a multiple of 5 and at least 5; checked at elaboration.
- CW, 8: credit/change register width in bits. Elaboration check: 2**CW-1 >= PRICE+20.

Ports:
- clk  in  1  system clock, all state updates on rising edge
- rst_n  in  1  asynchronous active-low reset
- nickel  in  1  one-cycle pulse, 5c coin inserted
- dime  in  1  one-cycle pulse, 10c coin inserted
- quarter  in  1  one-cycle pulse, 25c coin inserted
- cancel  in  1  one-cycle pulse, refund current credit
- release  out  1  one-cycle pulse, dispense item
- nickel_out  out  1  one-cycle pulse, pay out one 5c coin
- dime_out  out  1  one-cycle pulse, pay out one 10c coin
- coin_reject  out  1  one-cycle pulse, coin inserted this cycle is returned and not credited
- busy  out  1  high outside COLLECT
- credit  out  CW  current accumulated credit in cents

Behaviour:
- Reset (async assert, sync release): state=COLLECT; credit=0; change=0. All pulse outputs 0, busy=0.
- All outputs are registered or Moore-decoded from registers; no input-to-output combinational path.
- States: COLLECT, VEND, PAYOUT, REFUND.
- COLLECT, exactly one coin input high:
  - credit_n = credit + value.
  - If credit_n >= PRICE: next state VEND; change = credit_n - PRICE; credit = 0.
  - Otherwise credit = credit_n and state stays COLLECT.
- COLLECT, two or more coin inputs high in the same cycle: coin_reject=1 next cycle; credit unchanged.
- COLLECT, cancel=1:
  - credit > 0: change = credit; credit = 0; next state REFUND. Any coin that cycle is rejected (cancel wins).
  - credit == 0: cancel is ignored. A coin in the same cycle is processed normally.
- VEND: lasts exactly 1 cycle with release=1.
  - Next state PAYOUT if change > 0, else COLLECT.
  - A completing coin at edge n gives release high in cycle n+1.
- PAYOUT / REFUND: per cycle, Moore outputs from change:
  - change >= 10: dime_out=1.
  - change == 5: nickel_out=1.
  - At each edge, change is decremented by the amount paid. Go to COLLECT at the edge where change reaches 0.
  - Payout of c cents takes floor(c/10) + (c mod 10)/5 cycles.
- busy=1 in VEND, PAYOUT, REFUND. Any coin pulse in these states gives coin_reject=1 next cycle, credit unaffected. cancel is ignored.
- release is never asserted in REFUND.
- Width rule: sums are computed at CW+1 bits internally. Overflow is unreachable given the elaboration check.
- Reset mid-PAYOUT or mid-REFUND aborts immediately. Remaining change is discarded with no further pulses.

Decomposition:
- Package vend_pkg holds:
  - state_t enum {COLLECT, VEND, PAYOUT, REFUND}
  - localparams NICKEL_C=5, DIME_C=10, QUARTER_C=25
  - function coin_value(n, d, q), returning 0 on illegal combinations
- Sub-module vend_payout: loads change, emits dime/nickel pulses, counts down, and flags done. It is shared by PAYOUT and REFUND.
- The top level holds the credit FSM and reject logic.

Test Plan:
- PRICE=35; dime then quarter -> release one cycle after the quarter edge; no change pulses; credit returns to 0; busy high 1 cycle.
- nickel, dime, nickel, nickel, then quarter (50c) -> release; then dime_out; then nickel_out; then COLLECT.
- quarter, nickel, quarter (55c) -> release, then dime_out on 2 consecutive cycles.
- dime, nickel, then cancel -> no release; dime_out then nickel_out; credit 0.
- nickel+dime asserted together -> coin_reject pulse, credit unchanged. quarter during PAYOUT -> coin_reject, payout sequence unaltered. rst_n low mid-PAYOUT -> all outputs 0 at once, state COLLECT.
- PRICE=50, CW=8: quarter, quarter -> release, no change. Then dime x5 -> release on fifth dime, no change.

Source files
------------

// File: rtl/vend_pkg.sv
// Shared types, coin values and coin decoding for the vending controller.
package vend_pkg;

  typedef enum logic [1:0] {
    COLLECT = 2'd0,
    VEND    = 2'd1,
    PAYOUT  = 2'd2,
    REFUND  = 2'd3
  } state_t;

  localparam int unsigned NICKEL_C  = 5;
  localparam int unsigned DIME_C    = 10;
  localparam int unsigned QUARTER_C = 25;
  localparam int unsigned COIN_W    = 5;

  // Value of a single inserted coin; zero when no coin or several at once.
  function automatic logic [COIN_W-1:0] coin_value(input logic n, input logic d, input logic q);
    logic [COIN_W-1:0] v;
    case ({n, d, q})
      3'b100:  v = COIN_W'(NICKEL_C);
      3'b010:  v = COIN_W'(DIME_C);
      3'b001:  v = COIN_W'(QUARTER_C);
      default: v = '0;
    endcase
    return v;
  endfunction

endpackage

// File: rtl/vend_payout.sv
// Change dispenser: holds the owed amount and pays it out one coin per cycle,
// dimes first, while run is high. Shared by the vend-change and refund paths.
module vend_payout
  import vend_pkg::*;
#(
  parameter int unsigned CW = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          load,
  input  logic [CW-1:0] load_val,
  input  logic          run,
  output logic          dime_out,
  output logic          nickel_out,
  output logic          zero_c,
  output logic          done_c
);

  localparam logic [CW-1:0] DIME_V   = CW'(DIME_C);
  localparam logic [CW-1:0] NICKEL_V = CW'(NICKEL_C);

  logic [CW-1:0] change;
  logic [CW-1:0] paid_c;

  always_comb begin
    paid_c = '0;
    if (change >= DIME_V) begin
      paid_c = DIME_V;
    end else if (change == NICKEL_V) begin
      paid_c = NICKEL_V;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      change <= '0;
    end else if (load) begin
      change <= load_val;
    end else if (run) begin
      change <= change - paid_c;
    end
  end

  // Coin pulses are decoded from the change register while a payout is running.
  assign dime_out   = run && (change >= DIME_V);
  assign nickel_out = run && (change == NICKEL_V);
  assign zero_c     = (change == '0);
  assign done_c     = run && ((change == DIME_V) || (change == NICKEL_V));

endmodule

// File: rtl/vend_ctrl.sv
// Vending controller: accumulates coin credit toward PRICE, releases the item,
// then returns change or refunds on cancel through vend_payout.
module vend_ctrl
  import vend_pkg::*;
#(
  parameter int unsigned PRICE = 35,
  parameter int unsigned CW    = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          nickel,
  input  logic          dime,
  input  logic          quarter,
  input  logic          cancel,
  output logic          release_out,  // "release" is a reserved word
  output logic          nickel_out,
  output logic          dime_out,
  output logic          coin_reject,
  output logic          busy,
  output logic [CW-1:0] credit
);

  if ((PRICE < 5) || ((PRICE % 5) != 0)) begin : g_price_chk
    $error("vend_ctrl: PRICE must be a multiple of 5 and at least 5");
  end
  if (((64'd1 << CW) - 64'd1) < (64'(PRICE) + 64'd20)) begin : g_width_chk
    $error("vend_ctrl: CW too narrow for PRICE plus largest overshoot");
  end

  localparam logic [CW:0] PRICE_W = (CW+1)'(PRICE);

  state_t        state, state_n;
  logic [CW-1:0] credit_n;
  logic          reject_n;
  logic          load;
  logic [CW-1:0] load_val;
  logic          run;
  logic          zero_c;
  logic          done_c;
  logic [1:0]    coin_cnt;
  logic          any_coin;
  logic [CW:0]   sum;

  assign coin_cnt = 2'(nickel) + 2'(dime) + 2'(quarter);
  assign any_coin = (coin_cnt != 2'd0);
  assign sum      = {1'b0, credit} + (CW+1)'(coin_value(nickel, dime, quarter));
  assign run      = (state == PAYOUT) || (state == REFUND);

  // State, credit and reject registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= COLLECT;
      credit      <= '0;
      coin_reject <= 1'b0;
    end else begin
      state       <= state_n;
      credit      <= credit_n;
      coin_reject <= reject_n;
    end
  end

  // Next-state, credit update and change-load decisions.
  always_comb begin
    state_n  = state;
    credit_n = credit;
    reject_n = 1'b0;
    load     = 1'b0;
    load_val = '0;
    case (state)
      COLLECT: begin
        if (cancel && (credit != '0)) begin
          load     = 1'b1;
          load_val = credit;
          credit_n = '0;
          state_n  = REFUND;
          reject_n = any_coin;
        end else if (coin_cnt > 2'd1) begin
          reject_n = 1'b1;
        end else if (any_coin) begin
          if (sum >= PRICE_W) begin
            load     = 1'b1;
            load_val = CW'(sum - PRICE_W);
            credit_n = '0;
            state_n  = VEND;
          end else begin
            credit_n = CW'(sum);
          end
        end
      end
      VEND: begin
        reject_n = any_coin;
        state_n  = zero_c ? COLLECT : PAYOUT;
      end
      PAYOUT, REFUND: begin
        reject_n = any_coin;
        if (done_c) begin
          state_n = COLLECT;
        end
      end
      default: state_n = COLLECT;
    endcase
  end

  assign release_out = (state == VEND);
  assign busy        = (state != COLLECT);

  vend_payout #(.CW(CW)) u_payout (
    .clk        (clk),
    .rst_n      (rst_n),
    .load       (load),
    .load_val   (load_val),
    .run        (run),
    .dime_out   (dime_out),
    .nickel_out (nickel_out),
    .zero_c     (zero_c),
    .done_c     (done_c)
  );

endmodule
